// File: rtl/led_bar_peak_pkg.sv
// Shared constants, peak-dot state encoding and the level saturation helper
// for the LED bar column driver.
package led_bar_peak_pkg;

  localparam int N_LED_DEFAULT = 25;
  localparam int HEIGHT_W      = $clog2(N_LED_DEFAULT + 1);

  typedef logic [HEIGHT_W-1:0] height_t;

  localparam logic [1:0] PEAK_IDLE = 2'd0;
  localparam logic [1:0] PEAK_HOLD = 2'd1;
  localparam logic [1:0] PEAK_FALL = 2'd2;

  // Clamp at full input width first so levels like 200 never alias to a small height.
  function automatic height_t saturate(input logic [7:0] lvl, input int max_h);
    logic [7:0] lim;
    lim = 8'(max_h);
    return (lvl > lim) ? height_t'(lim) : height_t'(lvl);
  endfunction

endpackage

// File: rtl/led_bar_peak_mask_gen.sv
// Combinational LED mask: solid bar from the bottom plus a single peak dot.
module led_mask_gen
  import led_bar_peak_pkg::*;
#(
  parameter int N_LED = 25
) (
  input  logic [HEIGHT_W-1:0] bar_height,
  input  logic [HEIGHT_W-1:0] peak_pos,
  output logic [N_LED-1:0]    mask
);

  always_comb begin
    mask = '0;
    for (int i = 0; i < N_LED; i++) begin
      mask[i] = (i < int'(bar_height)) ||
                ((peak_pos != '0) && (i == int'(peak_pos) - 1));
    end
  end

endmodule

// File: rtl/led_bar_peak.sv
// LED bar column driver: instant attack, timed bar decay and a peak-hold dot
// that falls back onto the bar, with a registered on/off mask for the strip.
module led_bar_peak
  import led_bar_peak_pkg::*;
#(
  parameter int N_LED         = 25,
  parameter int HOLD_FRAMES   = 16,
  parameter int DECAY_DIV     = 2,
  parameter int PEAK_FALL_DIV = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                level_valid,
  input  logic [7:0]          level,
  input  logic                frame_tick,
  output logic [HEIGHT_W-1:0] bar_height,
  output logic [HEIGHT_W-1:0] peak_pos,
  output logic [N_LED-1:0]    led_mask,
  output logic                mask_update
);

  localparam int DCW = (DECAY_DIV > 1)     ? $clog2(DECAY_DIV)     : 1;
  localparam int HCW = (HOLD_FRAMES > 1)   ? $clog2(HOLD_FRAMES)   : 1;
  localparam int FCW = (PEAK_FALL_DIV > 1) ? $clog2(PEAK_FALL_DIV) : 1;

  localparam logic [DCW-1:0] DCNT_LAST = DCW'(DECAY_DIV - 1);
  localparam logic [HCW-1:0] HCNT_LAST = HCW'(HOLD_FRAMES - 1);
  localparam logic [FCW-1:0] FCNT_LAST = FCW'(PEAK_FALL_DIV - 1);

  logic [DCW-1:0]   dcnt, dcnt_next;
  logic [HCW-1:0]   hcnt, hcnt_next;
  logic [FCW-1:0]   fcnt, fcnt_next;
  logic [1:0]       peak_state, state_next;
  height_t          lvl_s, bar_dec, bar_next, peak_next, peak_dec;
  logic [N_LED-1:0] mask_next;
  logic             change_d;

  assign lvl_s = saturate(level, N_LED);

  // Attack is compared against the already-decayed bar, so a coincident tick
  // and level resolve to the larger of the two.
  always_comb begin
    bar_dec   = bar_height;
    dcnt_next = dcnt;
    if (frame_tick) begin
      if (dcnt == DCNT_LAST) begin
        dcnt_next = '0;
        if (bar_height != '0) begin
          bar_dec = bar_height - height_t'(1);
        end
      end else begin
        dcnt_next = dcnt + DCW'(1);
      end
    end
    bar_next = bar_dec;
    if (level_valid && (lvl_s > bar_dec)) begin
      bar_next  = lvl_s;
      dcnt_next = '0;
    end
  end

  always_comb begin
    peak_next  = peak_pos;
    state_next = peak_state;
    hcnt_next  = hcnt;
    fcnt_next  = fcnt;
    peak_dec   = peak_pos - height_t'(1);
    if (bar_next > peak_pos) begin
      peak_next  = bar_next;
      state_next = PEAK_HOLD;
      hcnt_next  = '0;
    end else begin
      case (peak_state)
        PEAK_IDLE: ;
        PEAK_HOLD: begin
          if (frame_tick) begin
            if (hcnt == HCNT_LAST) begin
              state_next = PEAK_FALL;
              fcnt_next  = '0;
            end else begin
              hcnt_next = hcnt + HCW'(1);
            end
          end
        end
        PEAK_FALL: begin
          if (frame_tick) begin
            if (fcnt == FCNT_LAST) begin
              fcnt_next = '0;
              // Once the falling dot meets the bar it rides the bar top.
              if ((peak_pos == '0) || (peak_dec <= bar_next)) begin
                peak_next = bar_next;
                if (bar_next == '0) begin
                  state_next = PEAK_IDLE;
                end
              end else begin
                peak_next = peak_dec;
              end
            end else begin
              fcnt_next = fcnt + FCW'(1);
            end
          end
        end
        default: state_next = PEAK_IDLE;
      endcase
    end
  end

  led_mask_gen #(
    .N_LED(N_LED)
  ) u_mask_gen (
    .bar_height(bar_next),
    .peak_pos  (peak_next),
    .mask      (mask_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      bar_height <= '0;
      dcnt       <= '0;
    end else begin
      bar_height <= bar_next;
      dcnt       <= dcnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      peak_pos   <= '0;
      peak_state <= PEAK_IDLE;
      hcnt       <= '0;
      fcnt       <= '0;
    end else begin
      peak_pos   <= peak_next;
      peak_state <= state_next;
      hcnt       <= hcnt_next;
      fcnt       <= fcnt_next;
    end
  end

  // mask_update trails the height change by one extra cycle for the serialiser.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_mask    <= '0;
      change_d    <= 1'b0;
      mask_update <= 1'b0;
    end else begin
      led_mask    <= mask_next;
      change_d    <= (bar_next != bar_height) || (peak_next != peak_pos);
      mask_update <= change_d;
    end
  end

endmodule

// File: tb/tb_led_bar_peak.sv
// Self-checking bench for led_bar_peak: directed scenarios followed by random
// traffic, all compared against a frame-count level model of the bar and dot.
module tb_led_bar_peak;
  import led_bar_peak_pkg::*;

  localparam int NL   = 25;
  localparam int HOLD = 16;
  localparam int DDIV = 2;
  localparam int PDIV = 4;

  localparam int M_IDLE = 0;
  localparam int M_HOLD = 1;
  localparam int M_FALL = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          level_valid;
  logic [7:0]    level;
  logic          frame_tick;
  logic [4:0]    bar_height;
  logic [4:0]    peak_pos;
  logic [NL-1:0] led_mask;
  logic          mask_update;

  int checks   = 0;
  int failures = 0;

  int m_bar, m_peak, m_dticks, m_mode, m_held, m_fell;
  bit m_chg, m_upd;

  always #5 clk = ~clk;

  led_bar_peak #(
    .N_LED(NL), .HOLD_FRAMES(HOLD), .DECAY_DIV(DDIV), .PEAK_FALL_DIV(PDIV)
  ) dut (
    .clk(clk), .rst(rst), .level_valid(level_valid), .level(level),
    .frame_tick(frame_tick), .bar_height(bar_height), .peak_pos(peak_pos),
    .led_mask(led_mask), .mask_update(mask_update)
  );

  function automatic logic [NL-1:0] exp_mask(int b, int p);
    logic [31:0] m;
    m = (32'd1 << b) - 32'd1;
    if (p != 0) m = m | (32'd1 << (p - 1));
    return m[NL-1:0];
  endfunction

  // Reference model: counts ticks since the last bar step / dot event.
  function automatic void model_step(bit r, bit lv, int lvl, bit tk);
    int sat, nb, np;
    bit chg;
    if (r) begin
      m_bar = 0; m_peak = 0; m_dticks = 0; m_mode = M_IDLE;
      m_held = 0; m_fell = 0; m_chg = 0; m_upd = 0;
      return;
    end
    sat = (lvl > NL) ? NL : lvl;
    nb = m_bar;
    if (tk) begin
      m_dticks++;
      if (m_dticks == DDIV) begin
        m_dticks = 0;
        if (nb > 0) nb--;
      end
    end
    if (lv && sat > nb) begin
      nb = sat;
      m_dticks = 0;
    end
    np = m_peak;
    if (nb > m_peak) begin
      np = nb; m_mode = M_HOLD; m_held = 0;
    end else if (tk && m_mode == M_HOLD) begin
      m_held++;
      if (m_held == HOLD) begin m_mode = M_FALL; m_fell = 0; end
    end else if (tk && m_mode == M_FALL) begin
      m_fell++;
      if (m_fell == PDIV) begin
        m_fell = 0;
        np = (m_peak - 1 > nb) ? m_peak - 1 : nb;
        if (np == 0) m_mode = M_IDLE;
      end
    end
    chg = (nb != m_bar) || (np != m_peak);
    m_upd = m_chg;
    m_chg = chg;
    m_bar = nb;
    m_peak = np;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic check_all();
    checkOutput("bar_height",  32'(bar_height),  32'(m_bar));
    checkOutput("peak_pos",    32'(peak_pos),    32'(m_peak));
    checkOutput("led_mask",    32'(led_mask),    32'(exp_mask(m_bar, m_peak)));
    checkOutput("mask_update", 32'(mask_update), 32'(m_upd));
  endtask

  // Drives one cycle of inputs from the falling edge and checks after the next rise.
  task automatic applyStimulus(input bit r, input bit lv, input int lvl, input bit tk);
    rst = r; level_valid = lv; level = 8'(lvl); frame_tick = tk;
    @(posedge clk);
    model_step(r, lv, lvl, tk);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rst = 1'b1; level_valid = 1'b0; level = 8'd0; frame_tick = 1'b0;
    @(negedge clk);

    $display("[TB] reset and idle with ticks");
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 1);
    checkOutput("reset_state", 32'(dut.peak_state), 32'(PEAK_IDLE));
    for (int i = 0; i < 100; i++) applyStimulus(0, 0, 0, (i % 4) == 0);
    checkOutput("idle_mask", 32'(led_mask), 32'd0);

    $display("[TB] saturating attack");
    applyStimulus(0, 1, 200, 0);
    checkOutput("sat_bar",  32'(bar_height), 32'd25);
    checkOutput("sat_peak", 32'(peak_pos),   32'd25);
    checkOutput("sat_mask", 32'(led_mask),   32'h1FF_FFFF);
    checkOutput("sat_upd_early", 32'(mask_update), 32'd0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("sat_upd", 32'(mask_update), 32'd1);
    applyStimulus(0, 0, 0, 0);

    $display("[TB] decay and peak fall from 12");
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 12, 0);
    for (int i = 0; i < 240; i++) applyStimulus(0, 0, 0, (i % 2) == 0);
    checkOutput("fall_end_state", 32'(dut.peak_state), 32'(PEAK_IDLE));
    checkOutput("fall_end_peak",  32'(peak_pos), 32'd0);

    $display("[TB] coincident attack during fall");
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 10, 0);
    for (int i = 0; i < 16; i++) applyStimulus(0, 1, 10, 1);
    checkOutput("pre_state", 32'(dut.peak_state), 32'(PEAK_FALL));
    checkOutput("pre_bar",   32'(bar_height), 32'd10);
    applyStimulus(0, 1, 18, 1);
    checkOutput("coin_bar",   32'(bar_height), 32'd18);
    checkOutput("coin_peak",  32'(peak_pos),   32'd18);
    checkOutput("coin_state", 32'(dut.peak_state), 32'(PEAK_HOLD));
    for (int i = 0; i < 60; i++) applyStimulus(0, 0, 0, 1);

    $display("[TB] non-attacking levels");
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 9, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 1, 5, 0);
    checkOutput("low_bar", 32'(bar_height), 32'd9);
    applyStimulus(0, 1, 9, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("low_upd", 32'(mask_update), 32'd0);

    $display("[TB] reset mid-fall");
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 14, 0);
    for (int i = 0; i < 17; i++) applyStimulus(0, 1, 7, 1);
    checkOutput("mid_bar",   32'(bar_height), 32'd7);
    checkOutput("mid_peak",  32'(peak_pos),   32'd14);
    checkOutput("mid_state", 32'(dut.peak_state), 32'(PEAK_FALL));
    applyStimulus(1, 0, 0, 0);
    checkOutput("rst_state", 32'(dut.peak_state), 32'(PEAK_IDLE));
    applyStimulus(0, 1, 3, 0);
    checkOutput("post_mask", 32'(led_mask), 32'h0000007);

    $display("[TB] random traffic");
    for (int i = 0; i < 2000; i++) begin
      int lvl;
      lvl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                         : int'($urandom_range(0, 30));
      applyStimulus($urandom_range(0, 499) == 0, $urandom_range(0, 7) == 0,
                    lvl, $urandom_range(0, 2) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
